// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic unit: function-select encoding.
package logic_unit_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOT  = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_PASS = 3'b111
  } op_e;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise function core with result flags.
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [WIDTH-1:0] res_c,
  output logic             zero_c,
  output logic             parity_c
);

  always_comb begin
    res_c = '0;
    unique case (op_e'(op_i))
      OP_AND:  res_c = a_i & y_i;
      OP_OR:   res_c = a_i | y_i;
      OP_XOR:  res_c = a_i ^ y_i;
      OP_NOT:  res_c = ~a_i;
      OP_NAND: res_c = ~(a_i & y_i);
      OP_NOR:  res_c = ~(a_i | y_i);
      OP_XNOR: res_c = ~(a_i ^ y_i);
      OP_PASS: res_c = y_i;
      default: res_c = '0;
    endcase
  end

  assign zero_c   = (res_c == '0);
  assign parity_c = ^res_c;

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit: valid/ready input, one-deep result register, accumulator operand.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [OP_W-1:0]  op,
  input  logic             use_acc,
  input  logic             acc_wr,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             zero,
  output logic             parity,
  output logic [WIDTH-1:0] acc
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH-1:0] a_c, res_c;
  logic             zero_c, parity_c;
  logic             accept_c, consume_c;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept_c  = in_valid && in_ready;
  assign consume_c = out_valid_q && out_ready;
  // Pre-clear accumulator feeds the operand even when acc_clr is asserted this cycle.
  assign a_c       = use_acc ? acc_q : x;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (a_c),
    .y_i      (y),
    .op_i     (op),
    .res_c    (res_c),
    .zero_c   (zero_c),
    .parity_c (parity_c)
  );

  // Next-state for the result register and accumulator.
  always_comb begin
    out_valid_d = out_valid_q;
    f_d         = f_q;
    zero_d      = zero_q;
    parity_d    = parity_q;
    acc_d       = acc_q;

    if (accept_c) begin
      out_valid_d = 1'b1;
      f_d         = res_c;
      zero_d      = zero_c;
      parity_d    = parity_c;
    end else if (consume_c) begin
      out_valid_d = 1'b0;
    end

    if (acc_clr) begin
      acc_d = '0;
    end else if (accept_c && acc_wr) begin
      acc_d = res_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      f_q         <= '0;
      zero_q      <= 1'b1;
      parity_q    <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      f_q         <= f_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: directed WIDTH=8 vectors plus random WIDTH=1/32 runs.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=8 instance (directed)
  logic       in_valid, in_ready, use_acc, acc_wr, acc_clr, out_valid, out_ready, zero, parity;
  logic [7:0] x, y, f, acc;
  logic [2:0] op;

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .op(op), .use_acc(use_acc), .acc_wr(acc_wr), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .f(f), .zero(zero),
    .parity(parity), .acc(acc)
  );

  // WIDTH=32 and WIDTH=1 instances (random)
  logic        r32_in_valid, r32_in_ready, r32_out_valid, r32_out_ready, r32_zero, r32_parity;
  logic [31:0] r32_x, r32_y, r32_f, r32_acc;
  logic [2:0]  r32_op;
  logic        r1_in_valid, r1_in_ready, r1_out_valid, r1_out_ready, r1_zero, r1_parity;
  logic [0:0]  r1_x, r1_y, r1_f, r1_acc;
  logic [2:0]  r1_op;

  logic_unit_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(r32_in_valid), .in_ready(r32_in_ready),
    .x(r32_x), .y(r32_y), .op(r32_op), .use_acc(1'b0), .acc_wr(1'b0), .acc_clr(1'b0),
    .out_valid(r32_out_valid), .out_ready(r32_out_ready), .f(r32_f), .zero(r32_zero),
    .parity(r32_parity), .acc(r32_acc)
  );

  logic_unit_pipe #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(r1_in_valid), .in_ready(r1_in_ready),
    .x(r1_x), .y(r1_y), .op(r1_op), .use_acc(1'b0), .acc_wr(1'b0), .acc_clr(1'b0),
    .out_valid(r1_out_valid), .out_ready(r1_out_ready), .f(r1_f), .zero(r1_zero),
    .parity(r1_parity), .acc(r1_acc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] f;
    string      name;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] sb32[$];
  logic [31:0] sb1[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] ref_op(logic [2:0] o, logic [31:0] a, logic [31:0] b,
                                         int unsigned w);
    logic [31:0] r, m;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'(1) << w) - 32'(1));
    case (o)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~a;
      3'd4: r = ~(a & b);
      3'd5: r = ~(a | b);
      3'd6: r = ~(a ^ b);
      default: r = b;
    endcase
    return r & m;
  endfunction

  // Monitors: pop one expected result per consumed output, then record newly accepted beats.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid && out_ready) begin
      if (sb.size() == 0) check("w8_unexpected_result", 32'(f), 32'hDEAD);
      else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_f"},      32'(f),      32'(e.f));
        check({e.name, "_zero"},   32'(zero),   32'(e.f == 8'h00));
        check({e.name, "_parity"}, 32'(parity), 32'(^e.f));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (r32_out_valid && r32_out_ready) begin
        if (sb32.size() == 0) check("w32_unexpected_result", r32_f, 32'hDEAD);
        else begin
          logic [31:0] e;
          e = sb32.pop_front();
          check("w32_f", r32_f, e);
          check("w32_zero", 32'(r32_zero), 32'(e == 32'd0));
          check("w32_parity", 32'(r32_parity), 32'(^e));
        end
      end
      if (r32_in_valid && r32_in_ready) sb32.push_back(ref_op(r32_op, r32_x, r32_y, 32));
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (r1_out_valid && r1_out_ready) begin
        if (sb1.size() == 0) check("w1_unexpected_result", 32'(r1_f), 32'hDEAD);
        else begin
          logic [31:0] e;
          e = sb1.pop_front();
          check("w1_f", 32'(r1_f), e);
          check("w1_zero", 32'(r1_zero), 32'(e == 32'd0));
          check("w1_parity", 32'(r1_parity), 32'(^e));
        end
      end
      if (r1_in_valid && r1_in_ready) sb1.push_back(ref_op(r1_op, 32'(r1_x), 32'(r1_y), 1));
    end
  end

  // Present a beat, wait (bounded) for in_ready, push its hand-computed result.
  task automatic beat(input logic [7:0] xv, input logic [7:0] yv, input logic [2:0] opv,
                      input logic ua, input logic aw, input logic ac,
                      input logic [7:0] ef, input string name);
    bit took;
    took     = 1'b0;
    x        = xv;
    y        = yv;
    op       = opv;
    use_acc  = ua;
    acc_wr   = aw;
    acc_clr  = ac;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{f: ef, name: name});
        took = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!took) check({name, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    use_acc  = 1'b0;
    acc_wr   = 1'b0;
    acc_clr  = 1'b0;
  endtask

  logic [7:0] sweep_exp [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sweep_exp = '{8'h30, 8'hB7, 8'h87, 8'h4D, 8'hCF, 8'h48, 8'h78, 8'h35};
    rst_n = 1'b0;
    in_valid = 1'b0; x = '0; y = '0; op = '0;
    use_acc = 1'b0; acc_wr = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    r32_in_valid = 1'b0; r32_out_ready = 1'b0; r32_x = '0; r32_y = '0; r32_op = '0;
    r1_in_valid  = 1'b0; r1_out_ready  = 1'b0; r1_x  = '0; r1_y  = '0; r1_op  = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_f",         32'(f),         32'd0);
    check("rst_zero",      32'(zero),      32'd1);
    check("rst_parity",    32'(parity),    32'd0);
    check("rst_acc",       32'(acc),       32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Op sweep on consecutive cycles.
    for (int k = 0; k < 8; k++)
      beat(8'hB2, 8'h35, 3'(k), 1'b0, 1'b0, 1'b0, sweep_exp[k], $sformatf("sweep_op%0d", k));
    check("sweep_latency_valid", 32'(out_valid), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: first beat lands, second stalls for 5 cycles.
    out_ready = 1'b0;
    beat(8'h0F, 8'hF0, 3'd1, 1'b0, 1'b0, 1'b0, 8'hFF, "bp_first");
    x = 8'h3C; y = 8'h0F; op = 3'd0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_f_stable",     32'(f),        32'hFF);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    beat(8'h3C, 8'h0F, 3'd0, 1'b0, 1'b0, 1'b0, 8'h0C, "bp_second");
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_second_f",     32'(f),         32'h0C);
    @(posedge clk);
    #1;

    // Accumulator chain.
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    check("acc_cleared", 32'(acc), 32'd0);
    beat(8'hFF, 8'h01, 3'd1, 1'b1, 1'b1, 1'b0, 8'h01, "chain0");
    beat(8'hFF, 8'h02, 3'd1, 1'b1, 1'b1, 1'b0, 8'h03, "chain1");
    beat(8'hFF, 8'h04, 3'd1, 1'b1, 1'b1, 1'b0, 8'h07, "chain2");
    beat(8'hFF, 8'h08, 3'd1, 1'b1, 1'b1, 1'b0, 8'h0F, "chain3");
    check("chain_acc", 32'(acc), 32'h0F);
    beat(8'h00, 8'h00, 3'd3, 1'b1, 1'b0, 1'b0, 8'hF0, "chain_not");
    check("chain_acc_kept", 32'(acc), 32'h0F);

    // acc_clr together with an accepted acc_wr beat: operand is pre-clear, clear wins.
    beat(8'h00, 8'hFF, 3'd2, 1'b1, 1'b1, 1'b1, 8'hF0, "clr_xor");
    check("clr_wins_acc", 32'(acc), 32'h00);

    // Zero flag.
    beat(8'hA5, 8'hA5, 3'd2, 1'b0, 1'b0, 1'b0, 8'h00, "zero_xor");

    // Reset while a result is held under backpressure.
    beat(8'h5A, 8'h00, 3'd1, 1'b0, 1'b1, 1'b0, 8'h5A, "pre_rst");
    check("pre_rst_acc", 32'(acc), 32'h5A);
    out_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_held", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_acc",       32'(acc),       32'd0);
    check("midrst_f",         32'(f),         32'd0);
    check("midrst_zero",      32'(zero),      32'd1);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    beat(8'hC3, 8'h0F, 3'd0, 1'b0, 1'b0, 1'b0, 8'h03, "post_rst_and");
    beat(8'hFF, 8'h3C, 3'd1, 1'b1, 1'b0, 1'b0, 8'h3C, "post_rst_acc0");
    repeat (3) @(posedge clk);
    #1;
    check("w8_sb_drained", 32'(sb.size()), 32'd0);

    // Random sweep at WIDTH=32 and WIDTH=1.
    fork
      begin
        for (int c = 0; c < 10000; c++) begin
          @(posedge clk);
          #1;
          r32_out_ready = 1'($urandom_range(0, 1));
          r32_in_valid  = 1'($urandom_range(0, 1));
          r32_x         = $urandom;
          r32_y         = $urandom;
          r32_op        = 3'($urandom_range(0, 7));
        end
        @(posedge clk);
        #1;
        r32_in_valid  = 1'b0;
        r32_out_ready = 1'b1;
      end
      begin
        for (int c = 0; c < 10000; c++) begin
          @(posedge clk);
          #1;
          r1_out_ready = 1'($urandom_range(0, 1));
          r1_in_valid  = 1'($urandom_range(0, 1));
          r1_x         = 1'($urandom_range(0, 1));
          r1_y         = 1'($urandom_range(0, 1));
          r1_op        = 3'($urandom_range(0, 7));
        end
        @(posedge clk);
        #1;
        r1_in_valid  = 1'b0;
        r1_out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("w32_sb_drained", 32'(sb32.size()), 32'd0);
    check("w1_sb_drained",  32'(sb1.size()),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
